// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Purpose  : Two-entry first-word-fall-through instruction queue between the
//            fetch and decode stages. Captures {pc, inst} pairs from fetch
//            with a valid/ready handshake and presents the head entry to
//            decode. Drives a NOP bubble when empty. A synchronous flush
//            discards every queued entry on a branch or jump redirect.
// Ports    : clk_i    - clock, rising edge
//            rst_i    - asynchronous active-high reset
//            flush_i  - synchronous flush, highest priority
//            valid_i  - fetch offers pc_i/inst_i this cycle
//            pc_i     - PC of the offered instruction
//            inst_i   - offered instruction
//            ready_o  - queue can accept a push this cycle
//            valid_o  - head entry is valid
//            pc_o     - PC of the head entry (0 when empty)
//            inst_o   - head instruction (NOP when empty)
//            ready_i  - decode consumes the head this cycle
//            count_o  - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter int          DEPTH  = 2,
    parameter int          ADDR_W = 6,
    parameter logic [31:0] NOP    = 32'h0000_0013
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  logic [ADDR_W-1:0]          pc_i,
    input  logic [31:0]                inst_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [ADDR_W-1:0]          pc_o,
    output logic [31:0]                inst_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // Entry storage; not reset, since occupancy alone decides validity.
    logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
    logic [31:0]        inst_mem_q [DEPTH];

    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0] count_q,  count_d;

    logic w_push;
    logic w_pop;

    // ready_o depends only on registered occupancy and reset, never on
    // ready_i: a full queue refuses a push even when the head pops.
    assign ready_o = (count_q != c_FULL) & ~rst_i;
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    assign w_push = valid_i & ready_o & ~flush_i;
    assign w_pop  = valid_o & ready_i & ~flush_i;

    // Head is presented combinationally; no bypass from pc_i/inst_i.
    assign inst_o = valid_o ? inst_mem_q[rd_ptr_q] : NOP;
    assign pc_o   = valid_o ? pc_mem_q[rd_ptr_q]   : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_ONE;
                2'b01:   count_d = count_q - c_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // w_push is already masked by reset through ready_o.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            pc_mem_q[wr_ptr_q]   <= pc_i;
            inst_mem_q[wr_ptr_q] <= inst_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_queue
// Purpose  : Directed self-checking bench for if_id_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic [5:0]  pc_i;
    logic [31:0] inst_i;
    logic        ready_o;
    logic        valid_o;
    logic [5:0]  pc_o;
    logic [31:0] inst_o;
    logic        ready_i;
    logic [1:0]  count_o;

    int checks = 0;
    int errors = 0;

    if_id_queue #(
        .DEPTH  (2),
        .ADDR_W (6),
        .NOP    (c_NOP)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .pc_i    (pc_i),
        .inst_i  (inst_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .pc_o    (pc_o),
        .inst_o  (inst_o),
        .ready_i (ready_i),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        pc_i = '0; inst_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (inst_o !== c_NOP) begin errors++; $display("FAIL reset_inst: got %h expected %h", inst_o, c_NOP); end
        checks++; if (pc_o !== 6'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_held: got %b expected 0", ready_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %b expected 1", ready_o); end
        step();
    endtask

    task automatic test_streaming();
        valid_i = 1'b1; ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_i = 6'(i); inst_i = 32'hA0 + 32'(i);
            step();
            checks++; if (inst_o !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL stream_inst%0d: got %h expected %h", i, inst_o, 32'hA0 + 32'(i)); end
            checks++; if (pc_o !== 6'(i)) begin errors++; $display("FAIL stream_pc%0d: got %h expected %h", i, pc_o, 6'(i)); end
            checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL stream_count%0d: got %0d expected 1", i, count_o); end
        end
        valid_i = 1'b0;
        step();
        checks++; if (valid_o !== 1'b0 || inst_o !== c_NOP) begin errors++; $display("FAIL stream_drain: got valid %b inst %h expected 0 %h", valid_o, inst_o, c_NOP); end
        ready_i = 1'b0;
    endtask

    task automatic test_fill_stall();
        ready_i = 1'b0; valid_i = 1'b1;
        pc_i = 6'd10; inst_i = 32'hB0; step();
        checks++; if (count_o !== 2'd1 || inst_o !== 32'hB0) begin errors++; $display("FAIL fill_first: got count %0d inst %h expected 1 b0", count_o, inst_o); end
        pc_i = 6'd11; inst_i = 32'hB1; step();
        checks++; if (count_o !== 2'd2 || ready_o !== 1'b0) begin errors++; $display("FAIL fill_full: got count %0d ready %b expected 2 0", count_o, ready_o); end
        pc_i = 6'd12; inst_i = 32'hB2; step();
        checks++; if (count_o !== 2'd2 || inst_o !== 32'hB0 || pc_o !== 6'd10) begin errors++; $display("FAIL fill_hold: got count %0d inst %h pc %0d expected 2 b0 10", count_o, inst_o, pc_o); end
        ready_i = 1'b1; step();
        checks++; if (inst_o !== 32'hB1 || count_o !== 2'd1) begin errors++; $display("FAIL stall_out1: got inst %h count %0d expected b1 1", inst_o, count_o); end
        step();
        checks++; if (inst_o !== 32'hB2 || pc_o !== 6'd12 || count_o !== 2'd1) begin errors++; $display("FAIL stall_out2: got inst %h pc %0d count %0d expected b2 12 1", inst_o, pc_o, count_o); end
        valid_i = 1'b0; step();
        checks++; if (count_o !== 2'd0 || valid_o !== 1'b0) begin errors++; $display("FAIL stall_drain: got count %0d valid %b expected 0 0", count_o, valid_o); end
        ready_i = 1'b0;
    endtask

    task automatic test_full_pop();
        ready_i = 1'b0; valid_i = 1'b1;
        pc_i = 6'd20; inst_i = 32'hD0; step();
        pc_i = 6'd21; inst_i = 32'hD1; step();
        ready_i = 1'b1; pc_i = 6'd22; inst_i = 32'hD2; step();
        checks++; if (count_o !== 2'd1 || inst_o !== 32'hD1) begin errors++; $display("FAIL fullpop_nopush: got count %0d inst %h expected 1 d1", count_o, inst_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fullpop_ready: got %b expected 1", ready_o); end
        step();
        checks++; if (count_o !== 2'd1 || inst_o !== 32'hD2 || pc_o !== 6'd22) begin errors++; $display("FAIL fullpop_accept: got count %0d inst %h pc %0d expected 1 d2 22", count_o, inst_o, pc_o); end
        valid_i = 1'b0; step();
        ready_i = 1'b0;
    endtask

    task automatic test_flush();
        ready_i = 1'b0; valid_i = 1'b1;
        pc_i = 6'd30; inst_i = 32'hE0; step();
        pc_i = 6'd31; inst_i = 32'hE1; step();
        flush_i = 1'b1; ready_i = 1'b1; pc_i = 6'd32; inst_i = 32'hE2; step();
        checks++; if (count_o !== 2'd0 || valid_o !== 1'b0) begin errors++; $display("FAIL flush_count: got count %0d valid %b expected 0 0", count_o, valid_o); end
        checks++; if (inst_o !== c_NOP || pc_o !== 6'd0) begin errors++; $display("FAIL flush_outputs: got inst %h pc %0d expected %h 0", inst_o, pc_o, c_NOP); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", ready_o); end
        flush_i = 1'b0; ready_i = 1'b0; pc_i = 6'd5; inst_i = 32'hC0; step();
        checks++; if (count_o !== 2'd1 || inst_o !== 32'hC0 || pc_o !== 6'd5) begin errors++; $display("FAIL flush_next_push: got count %0d inst %h pc %0d expected 1 c0 5", count_o, inst_o, pc_o); end
        valid_i = 1'b0; ready_i = 1'b1; step();
        checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL flush_dropped: got count %0d expected 0", count_o); end
        ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        logic [37:0] model[$];
        logic        exp_push, exp_pop;
        logic [31:0] exp_inst;
        logic [5:0]  exp_pc;
        int          seq;
        seq = 0;
        valid_i = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            // A refused offer is held until accepted; otherwise pick afresh.
            if (!valid_i) valid_i = 1'($urandom_range(0, 3) != 0);
            pc_i   = 6'(seq);
            inst_i = 32'hF000_0000 | 32'(seq);
            ready_i = 1'($urandom_range(0, 1));
            exp_push = valid_i && (model.size() < 2);
            exp_pop  = ready_i && (model.size() > 0);
            step();
            if (exp_pop) void'(model.pop_front());
            if (exp_push) begin
                model.push_back({pc_i, inst_i});
                seq++;
                valid_i = 1'b0;
            end
            exp_inst = (model.size() > 0) ? model[0][31:0]  : c_NOP;
            exp_pc   = (model.size() > 0) ? model[0][37:32] : 6'd0;
            checks++; if (count_o !== 2'(model.size())) begin errors++; $display("FAIL wrap_count%0d: got %0d expected %0d", cyc, count_o, model.size()); end
            checks++; if (inst_o !== exp_inst || pc_o !== exp_pc) begin errors++; $display("FAIL wrap_head%0d: got inst %h pc %0d expected %h %0d", cyc, inst_o, pc_o, exp_inst, exp_pc); end
        end
        checks++; if (seq < 10) begin errors++; $display("FAIL wrap_progress: got %0d pushes expected at least 10", seq); end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) step();
        ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0; valid_i = 1'b1;
        pc_i = 6'd40; inst_i = 32'h50; step();
        pc_i = 6'd41; inst_i = 32'h51; step();
        checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL rstmid_pre: got count %0d expected 2", count_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (count_o !== 2'd0 || valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_count: got count %0d valid %b expected 0 0", count_o, valid_o); end
        checks++; if (inst_o !== c_NOP || pc_o !== 6'd0 || ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got inst %h pc %0d ready %b expected %h 0 0", inst_o, pc_o, ready_o, c_NOP); end
        ready_i = 1'b1; step();
        checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL rstmid_no_push: got count %0d expected 0", count_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_release: got %b expected 1", ready_o); end
        ready_i = 1'b0; pc_i = 6'd42; inst_i = 32'h52; step();
        checks++; if (inst_o !== 32'h52 || count_o !== 2'd1) begin errors++; $display("FAIL rstmid_after: got inst %h count %0d expected 52 1", inst_o, count_o); end
        valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_stall();
        test_full_pop();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
